// File: rtl/kv_tree_plru.sv
// kv_tree_plru -- tree pseudo-LRU replacement engine for set-associative caches.
//
// Keeps WAYS-1 tree bits per set. A touch (hit or fill) points every node on
// the path to the touched way away from it. A lookup returns a registered
// one-hot victim one cycle later: invalid ways first (lowest number), then the
// tree walk, never a locked way. A touch to the looked-up set in the same cycle
// is applied before the walk (write-before-read bypass).
//
// Ports:
//   i_clk          clock, rising edge
//   i_rstn         synchronous active-low reset
//   i_req          lookup strobe
//   i_index        set addressed by the lookup
//   i_valid_way    per-way valid bits of the looked-up set
//   i_lock_way     per-way lock bits (locked ways are never victims)
//   i_touch_en     touch strobe
//   i_touch_index  set being touched
//   i_hitway       one-hot touched way (zero / multi-hot touches are ignored)
//   o_kill_valid   one-cycle pulse per lookup; o_killmask/o_all_locked valid
//   o_killmask     one-hot victim, or zero when every way is locked
//   o_all_locked   every way of the looked-up set is locked
module kv_tree_plru #(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    parameter int IDXW = $clog2(SETS)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_req,
    input  logic [IDXW-1:0] i_index,
    input  logic [WAYS-1:0] i_valid_way,
    input  logic [WAYS-1:0] i_lock_way,
    input  logic            i_touch_en,
    input  logic [IDXW-1:0] i_touch_index,
    input  logic [WAYS-1:0] i_hitway,
    output logic            o_kill_valid,
    output logic [WAYS-1:0] o_killmask,
    output logic            o_all_locked
);

    localparam int LEVELS = $clog2(WAYS);
    localparam int NODES  = WAYS - 1;
    localparam logic [WAYS-1:0] ONE_W = {{(WAYS-1){1'b0}}, 1'b1};

    typedef logic [NODES-1:0] tree_t;

    tree_t           tree_r [SETS];
    logic            kill_valid_r;
    logic [WAYS-1:0] killmask_r;
    logic            all_locked_r;

    logic            touch_ok_s;
    tree_t           touched_s;
    tree_t           eff_tree_s;
    logic [WAYS:0]   pick_s;

    function automatic logic is_onehot(input logic [WAYS-1:0] v);
        return (v != {WAYS{1'b0}}) && ((v & (v - ONE_W)) == {WAYS{1'b0}});
    endfunction

    // Walk root-to-leaf along the touched way, pointing each node away from it.
    function automatic tree_t touch_tree(input tree_t t, input logic [WAYS-1:0] hit);
        tree_t r;
        int    way;
        int    node;
        logic  dir_b;
        r    = t;
        way  = 0;
        node = 0;
        for (int k = 0; k < WAYS; k++) begin
            way = hit[k] ? k : way;
        end
        for (int l = 0; l < LEVELS; l++) begin
            dir_b = (((way >> (LEVELS - 1 - l)) & 1) != 0);
            for (int k = 0; k < NODES; k++) begin
                r[k] = (k == node) ? ~dir_b : r[k];
            end
            node = 2 * node + 1 + (dir_b ? 1 : 0);
        end
        return r;
    endfunction

    // Returns {all_locked, killmask}. The walk tracks the leaf range under the
    // current node; a preferred half that is fully locked is skipped, which can
    // never strand the walk because the whole set is known not to be locked.
    function automatic logic [WAYS:0] pick_victim(input tree_t t,
                                                  input logic [WAYS-1:0] valid,
                                                  input logic [WAYS-1:0] lock);
        logic [WAYS-1:0] cand;
        logic [WAYS-1:0] mask;
        logic            all_locked;
        logic            dir_b;
        logic            lo_locked;
        logic            hi_locked;
        int              node;
        int              base;
        int              half;
        cand       = ~valid & ~lock;
        mask       = {WAYS{1'b0}};
        all_locked = 1'b0;
        node       = 0;
        base       = 0;
        if (&lock) begin
            all_locked = 1'b1;
        end else if (cand != {WAYS{1'b0}}) begin
            mask = cand & (~cand + ONE_W);
        end else begin
            for (int l = 0; l < LEVELS; l++) begin
                half      = WAYS >> (l + 1);
                dir_b     = 1'b0;
                lo_locked = 1'b1;
                hi_locked = 1'b1;
                for (int k = 0; k < NODES; k++) begin
                    dir_b = (k == node) ? t[k] : dir_b;
                end
                for (int k = 0; k < WAYS; k++) begin
                    lo_locked &= (k >= base && k < base + half) ? lock[k] : 1'b1;
                    hi_locked &= (k >= base + half && k < base + 2 * half) ? lock[k] : 1'b1;
                end
                if (!dir_b && lo_locked) begin
                    dir_b = 1'b1;
                end else if (dir_b && hi_locked) begin
                    dir_b = 1'b0;
                end else begin
                    dir_b = dir_b;
                end
                base = base + (dir_b ? half : 0);
                node = 2 * node + 1 + (dir_b ? 1 : 0);
            end
            for (int k = 0; k < WAYS; k++) begin
                mask[k] = (k == base);
            end
        end
        return {all_locked, mask};
    endfunction

    // Touch decode, same-set bypass and victim selection.
    always_comb begin
        touch_ok_s = i_touch_en && is_onehot(i_hitway);
        touched_s  = touch_tree(tree_r[i_touch_index], i_hitway);
        if (touch_ok_s && (i_touch_index == i_index)) begin
            eff_tree_s = touched_s;
        end else begin
            eff_tree_s = tree_r[i_index];
        end
        pick_s = pick_victim(eff_tree_s, i_valid_way, i_lock_way);
    end

    // Tree state: cleared on reset, updated by valid touches only.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int s = 0; s < SETS; s++) begin
                tree_r[s] <= {NODES{1'b0}};
            end
        end else if (touch_ok_s) begin
            tree_r[i_touch_index] <= touched_s;
        end
    end

    // Registered lookup result; mask and all-locked hold between requests.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            kill_valid_r <= 1'b0;
            killmask_r   <= {WAYS{1'b0}};
            all_locked_r <= 1'b0;
        end else begin
            kill_valid_r <= i_req;
            if (i_req) begin
                killmask_r   <= pick_s[WAYS-1:0];
                all_locked_r <= pick_s[WAYS];
            end
        end
    end

    assign o_kill_valid = kill_valid_r;
    assign o_killmask   = killmask_r;
    assign o_all_locked = all_locked_r;

endmodule

// File: tb/tb_kv_tree_plru.sv
// Scoreboard bench for kv_tree_plru (WAYS=4, SETS=16): directed lookups push
// their hand-computed result; a negedge monitor pops and compares on every
// o_kill_valid pulse and flags pulses nobody asked for.
module tb_kv_tree_plru;

    localparam int WAYS = 4;
    localparam int SETS = 16;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            i_rstn;
    logic            i_req;
    logic [IDXW-1:0] i_index;
    logic [WAYS-1:0] i_valid_way;
    logic [WAYS-1:0] i_lock_way;
    logic            i_touch_en;
    logic [IDXW-1:0] i_touch_index;
    logic [WAYS-1:0] i_hitway;
    logic            o_kill_valid;
    logic [WAYS-1:0] o_killmask;
    logic            o_all_locked;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WAYS:0] exp_q [$];
    string         name_q [$];
    logic [WAYS:0] mon_exp;
    string         mon_name;

    always #5 clk = ~clk;

    kv_tree_plru #(.WAYS(WAYS), .SETS(SETS)) dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_req        (i_req),
        .i_index      (i_index),
        .i_valid_way  (i_valid_way),
        .i_lock_way   (i_lock_way),
        .i_touch_en   (i_touch_en),
        .i_touch_index(i_touch_index),
        .i_hitway     (i_hitway),
        .o_kill_valid (o_kill_valid),
        .o_killmask   (o_killmask),
        .o_all_locked (o_all_locked)
    );

    task automatic check(input string nm, input logic [WAYS:0] act, input logic [WAYS:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {all_locked,mask}=%b, expected %b", nm, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_kill_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: o_kill_valid=1 mask=%b, expected no pulse", o_killmask);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, {o_all_locked, o_killmask}, mon_exp);
            end
        end
    end

    task automatic drive(input logic req, input logic [IDXW-1:0] idx,
                         input logic [WAYS-1:0] vld, input logic [WAYS-1:0] lck,
                         input logic tch, input logic [IDXW-1:0] tidx,
                         input logic [WAYS-1:0] hit);
        i_req         = req;
        i_index       = idx;
        i_valid_way   = vld;
        i_lock_way    = lck;
        i_touch_en    = tch;
        i_touch_index = tidx;
        i_hitway      = hit;
        @(posedge clk);
        #1;
        i_req      = 1'b0;
        i_touch_en = 1'b0;
    endtask

    task automatic expect_res(input logic al, input logic [WAYS-1:0] mask, input string nm);
        exp_q.push_back({al, mask});
        name_q.push_back(nm);
    endtask

    task automatic lookup(input logic [IDXW-1:0] idx, input logic [WAYS-1:0] vld,
                          input logic [WAYS-1:0] lck, input logic al,
                          input logic [WAYS-1:0] mask, input string nm);
        expect_res(al, mask, nm);
        drive(1'b1, idx, vld, lck, 1'b0, 4'd0, 4'b0000);
    endtask

    task automatic touch(input logic [IDXW-1:0] tidx, input logic [WAYS-1:0] hit);
        drive(1'b0, 4'd0, 4'b1111, 4'b0000, 1'b1, tidx, hit);
    endtask

    initial begin
        i_rstn = 1'b0;
        i_req = 1'b0; i_index = 4'd0; i_valid_way = 4'b0000; i_lock_way = 4'b0000;
        i_touch_en = 1'b0; i_touch_index = 4'd0; i_hitway = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {o_all_locked, o_killmask}, 5'b00000);
        check("reset_kill_valid", {4'b0000, o_kill_valid}, 5'b00000);
        i_rstn = 1'b1;
        @(posedge clk);
        #1;

        // Invalid way takes priority over the tree
        lookup(4'd3, 4'b0001, 4'b0000, 1'b0, 4'b0010, "invalid_priority");

        // Tree walk on set 0
        lookup(4'd0, 4'b1111, 4'b0000, 1'b0, 4'b0001, "walk_reset");
        touch(4'd0, 4'b0001);
        lookup(4'd0, 4'b1111, 4'b0000, 1'b0, 4'b0100, "walk_after_w0");
        touch(4'd0, 4'b0100);
        lookup(4'd0, 4'b1111, 4'b0000, 1'b0, 4'b0010, "walk_after_w2");
        touch(4'd0, 4'b0010);
        lookup(4'd0, 4'b1111, 4'b0000, 1'b0, 4'b1000, "walk_after_w1");

        // Same-cycle bypass, then ignored multi-hot and zero touches
        expect_res(1'b0, 4'b0100, "bypass_same_cycle");
        drive(1'b1, 4'd5, 4'b1111, 4'b0000, 1'b1, 4'd5, 4'b0001);
        touch(4'd5, 4'b0011);
        lookup(4'd5, 4'b1111, 4'b0000, 1'b0, 4'b0100, "multihot_ignored");
        touch(4'd5, 4'b0000);
        lookup(4'd5, 4'b1111, 4'b0000, 1'b0, 4'b0100, "zero_touch_ignored");

        // Locks on an untouched set
        lookup(4'd9, 4'b1111, 4'b0001, 1'b0, 4'b0010, "lock_w0");
        lookup(4'd9, 4'b1111, 4'b0011, 1'b0, 4'b0100, "lock_left_half");
        lookup(4'd9, 4'b1111, 4'b1111, 1'b1, 4'b0000, "all_locked");
        lookup(4'd9, 4'b0000, 4'b0001, 1'b0, 4'b0010, "invalid_but_locked");

        // Index isolation and back-to-back lookups
        touch(4'd7, 4'b0001);
        lookup(4'd8, 4'b1111, 4'b0000, 1'b0, 4'b0001, "isolation_idx8");
        lookup(4'd7, 4'b1111, 4'b0000, 1'b0, 4'b0100, "b2b_idx7");
        lookup(4'd8, 4'b1111, 4'b0000, 1'b0, 4'b0001, "b2b_idx8");

        // Result holds once the pulse is gone
        @(posedge clk);
        #1;
        check("hold_result", {o_all_locked, o_killmask}, 5'b00001);
        check("pulse_one_cycle", {4'b0000, o_kill_valid}, 5'b00000);

        // Touch and lookup to different sets in one cycle are independent
        expect_res(1'b0, 4'b0001, "diff_index_lookup");
        drive(1'b1, 4'd11, 4'b1111, 4'b0000, 1'b1, 4'd10, 4'b0001);
        lookup(4'd10, 4'b1111, 4'b0000, 1'b0, 4'b0100, "diff_index_touched");

        // Reset mid-operation: in-flight lookup dropped, touch ignored
        expect_res(1'b0, 4'b0010, "pre_reset_lookup");
        drive(1'b1, 4'd4, 4'b1111, 4'b0001, 1'b1, 4'd2, 4'b0001);
        i_rstn = 1'b0;
        drive(1'b1, 4'd2, 4'b1111, 4'b0000, 1'b1, 4'd2, 4'b0001);
        check("midreset_outputs", {o_all_locked, o_killmask}, 5'b00000);
        check("midreset_kill_valid", {4'b0000, o_kill_valid}, 5'b00000);
        i_rstn = 1'b1;
        @(posedge clk);
        #1;
        lookup(4'd2, 4'b1111, 4'b0000, 1'b0, 4'b0001, "after_reset_idx2");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        while (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no o_kill_valid pulse, expected {all_locked,mask}=%b", mon_name, mon_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
